// File: rtl/int_ctrl.sv
// Machine-mode trap/mret sequencer: accepts one event in IDLE, writes mepc/mcause/mstatus
// over successive cycles, then pulses int_enable_o with the redirect target.
module int_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  irq_ext_i,
  input  logic                  irq_timer_i,
  input  logic [31:0]           id_inst_i,
  input  logic [ADDR_WIDTH-1:0] id_inst_addr_i,
  input  logic                  jump_enable_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  stall_i,
  input  logic [ADDR_WIDTH-1:0] csr_mtvec_i,
  input  logic [ADDR_WIDTH-1:0] csr_mepc_i,
  input  logic [ADDR_WIDTH-1:0] csr_mstatus_i,
  input  logic [ADDR_WIDTH-1:0] csr_mie_i,
  output logic                  csr_we_o,
  output logic [11:0]           csr_waddr_o,
  output logic [ADDR_WIDTH-1:0] csr_wdata_o,
  output logic                  int_enable_o,
  output logic [ADDR_WIDTH-1:0] isr_addr_o,
  output logic                  int_busy_o
);

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [ADDR_WIDTH-1:0] CAUSE_ECALL  = ADDR_WIDTH'(11);
  localparam logic [ADDR_WIDTH-1:0] CAUSE_EBREAK = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] CAUSE_EXT    = {1'b1, {(ADDR_WIDTH-5){1'b0}}, 4'd11};
  localparam logic [ADDR_WIDTH-1:0] CAUSE_TIMER  = {1'b1, {(ADDR_WIDTH-5){1'b0}}, 4'd7};

  typedef enum logic [2:0] {
    IDLE,
    WR_MEPC,
    WR_MCAUSE,
    WR_MSTAT,
    WR_MSTAT_RET,
    PULSE
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   cause_reg, cause_next;
  logic [ADDR_WIDTH-1:0]   snap_reg, snap_next;
  logic [ADDR_WIDTH-1:0]   mtvec_reg, mtvec_next;
  logic [ADDR_WIDTH-1:0]   mepc_reg, mepc_next;
  logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
  logic                    ret_reg, ret_next;

  logic                    sync_ok;
  logic                    ev_ecall, ev_ebreak, ev_mret, ev_ext, ev_timer, ev_any;
  logic [ADDR_WIDTH-1:0]   async_pc;
  logic [ADDR_WIDTH-1:0]   mstat_trap, mstat_ret;

  // Only MEIE/MTIE matter here; the other mie bits are deliberately ignored.
  logic unused_mie;
  assign unused_mie = ^{csr_mie_i[ADDR_WIDTH-1:12], csr_mie_i[10:8], csr_mie_i[6:0]};

  // A resolved jump means the ID instruction is being flushed, so it cannot trap.
  assign sync_ok   = !stall_i && !jump_enable_i;
  assign ev_ecall  = sync_ok && (id_inst_i == INST_ECALL);
  assign ev_ebreak = sync_ok && (id_inst_i == INST_EBREAK);
  assign ev_mret   = sync_ok && (id_inst_i == INST_MRET);
  assign ev_ext    = !stall_i && irq_ext_i && csr_mstatus_i[3] && csr_mie_i[11];
  assign ev_timer  = !stall_i && irq_timer_i && csr_mstatus_i[3] && csr_mie_i[7];
  assign ev_any    = ev_ecall || ev_ebreak || ev_mret || ev_ext || ev_timer;
  assign async_pc  = jump_enable_i ? jump_addr_i : id_inst_addr_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cause_reg <= '0;
      snap_reg  <= '0;
      mtvec_reg <= '0;
      mepc_reg  <= '0;
      pc_reg    <= '0;
      ret_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
      snap_reg  <= snap_next;
      mtvec_reg <= mtvec_next;
      mepc_reg  <= mepc_next;
      pc_reg    <= pc_next;
      ret_reg   <= ret_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cause_next   = cause_reg;
    snap_next    = snap_reg;
    mtvec_next   = mtvec_reg;
    mepc_next    = mepc_reg;
    pc_next      = pc_reg;
    ret_next     = ret_reg;
    csr_we_o     = 1'b0;
    csr_waddr_o  = '0;
    csr_wdata_o  = '0;
    int_enable_o = 1'b0;
    isr_addr_o   = '0;
    int_busy_o   = 1'b0;

    // Trap entry stacks MIE into MPIE; mret restores MIE from MPIE and sets MPIE.
    mstat_trap    = snap_reg;
    mstat_trap[7] = snap_reg[3];
    mstat_trap[3] = 1'b0;
    mstat_ret     = snap_reg;
    mstat_ret[3]  = snap_reg[7];
    mstat_ret[7]  = 1'b1;

    case (state_reg)
      IDLE: begin
        if (ev_any) begin
          int_busy_o = 1'b1;
          snap_next  = csr_mstatus_i;
          mtvec_next = csr_mtvec_i;
          mepc_next  = csr_mepc_i;
          pc_next    = id_inst_addr_i;
          ret_next   = 1'b0;
          state_next = WR_MEPC;
          if (ev_ecall) begin
            cause_next = CAUSE_ECALL;
          end else if (ev_ebreak) begin
            cause_next = CAUSE_EBREAK;
          end else if (ev_mret) begin
            ret_next   = 1'b1;
            state_next = WR_MSTAT_RET;
          end else if (ev_ext) begin
            cause_next = CAUSE_EXT;
            pc_next    = async_pc;
          end else begin
            cause_next = CAUSE_TIMER;
            pc_next    = async_pc;
          end
        end
      end
      WR_MEPC: begin
        int_busy_o  = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = pc_reg;
        state_next  = WR_MCAUSE;
      end
      WR_MCAUSE: begin
        int_busy_o  = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = cause_reg;
        state_next  = WR_MSTAT;
      end
      WR_MSTAT: begin
        int_busy_o  = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = mstat_trap;
        state_next  = PULSE;
      end
      WR_MSTAT_RET: begin
        int_busy_o  = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = mstat_ret;
        state_next  = PULSE;
      end
      PULSE: begin
        int_enable_o = 1'b1;
        isr_addr_o   = ret_reg ? mepc_reg : {mtvec_reg[ADDR_WIDTH-1:2], 2'b00};
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Table-driven bench for int_ctrl: each accepted event queues its expected CSR writes and
// redirect pulse with due cycles; a per-cycle monitor pops and compares them.
module tb_int_ctrl;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq_ext, irq_timer, jump_en, stall;
  logic [31:0] id_inst, id_addr, jump_addr;
  logic [31:0] mtvec, mepc, mstatus, mie;
  logic        csr_we, int_enable, int_busy;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, isr_addr;

  int_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .irq_ext_i(irq_ext), .irq_timer_i(irq_timer),
    .id_inst_i(id_inst), .id_inst_addr_i(id_addr), .jump_enable_i(jump_en),
    .jump_addr_i(jump_addr), .stall_i(stall), .csr_mtvec_i(mtvec), .csr_mepc_i(mepc),
    .csr_mstatus_i(mstatus), .csr_mie_i(mie), .csr_we_o(csr_we), .csr_waddr_o(csr_waddr),
    .csr_wdata_o(csr_wdata), .int_enable_o(int_enable), .isr_addr_o(isr_addr),
    .int_busy_o(int_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst, addr;
    logic        ext, tmr, jen;
    logic [31:0] jaddr, mstatus, mie, mtvec, mepc;
    logic        acc, ret;
    logic [31:0] e_mepc, e_cause, e_mstat, e_isr;
  } vec_t;

  typedef struct {
    logic        pulse;
    logic [11:0] addr;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q[$];
  vec_t vecs[13];
  int   npass = 0;
  int   ntot  = 0;
  int   cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input logic pulse, input logic [11:0] addr, input logic [31:0] data,
                      input int k);
    exp_t e;
    e.pulse = pulse; e.addr = addr; e.data = data; e.due = cyc + 1 + k;
    q.push_back(e);
  endtask

  task automatic push_trap(input logic [31:0] pc, input logic [31:0] cause,
                           input logic [31:0] mst, input logic [31:0] isr);
    push(1'b0, 12'h341, pc, 1);
    push(1'b0, 12'h342, cause, 2);
    push(1'b0, 12'h300, mst, 3);
    push(1'b1, 12'h000, isr, 4);
  endtask

  task automatic push_ret(input logic [31:0] mst, input logic [31:0] isr);
    push(1'b0, 12'h300, mst, 1);
    push(1'b1, 12'h000, isr, 2);
  endtask

  // Monitor at the falling edge, then return just after the next rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (csr_we || int_enable) begin
      if (q.size() == 0) begin
        chk("unexpected_event", {30'b0, csr_we, int_enable}, 32'h0);
      end else begin
        e = q.pop_front();
        $display("cycle %0d: we=%0d addr=%03h data=%08h pulse=%0d isr=%08h", cyc, csr_we,
                 csr_waddr, csr_wdata, int_enable, isr_addr);
        chk("event_cycle", cyc, e.due);
        chk("pulse_flag", int_enable, e.pulse);
        chk("csr_we_flag", csr_we, !e.pulse);
        chk("csr_waddr", csr_waddr, e.addr);
        chk(e.pulse ? "isr_addr" : "csr_wdata", e.pulse ? isr_addr : csr_wdata, e.data);
      end
    end else begin
      chk("quiet_outputs", {31'b0, (|csr_waddr) | (|csr_wdata) | (|isr_addr)}, 32'h0);
      if (q.size() > 0 && q[0].due <= cyc) begin
        chk("missed_event", {31'b0, csr_we | int_enable}, 32'h1);
        void'(q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    id_inst = NOP; irq_ext = 1'b0; irq_timer = 1'b0; jump_en = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    id_inst = v.inst; id_addr = v.addr; irq_ext = v.ext; irq_timer = v.tmr;
    jump_en = v.jen; jump_addr = v.jaddr; mstatus = v.mstatus; mie = v.mie;
    mtvec = v.mtvec; mepc = v.mepc;
    #1;
    chk("busy_accept", int_busy, v.acc);
    if (v.acc && v.ret) push_ret(v.e_mstat, v.e_isr);
    else if (v.acc) push_trap(v.e_mepc, v.e_cause, v.e_mstat, v.e_isr);
    step();
    clear_events();
    repeat (5) step();
  endtask

  initial begin
    // inst addr ext tmr jen jaddr mstatus mie mtvec mepc acc ret | mepc cause mstatus isr
    vecs[0]  = '{NOP,    32'h100, 1, 0, 0, 32'h0,  32'h8,    32'h800, 32'h200, 32'h0,    1, 0, 32'h100, 32'h8000000B, 32'h80,   32'h200};
    vecs[1]  = '{ECALL,  32'h40,  0, 0, 0, 32'h0,  32'h0,    32'h0,   32'h203, 32'h0,    1, 0, 32'h40,  32'd11,        32'h0,    32'h200};
    vecs[2]  = '{EBREAK, 32'h58,  0, 0, 0, 32'h0,  32'h8,    32'h0,   32'h300, 32'h0,    1, 0, 32'h58,  32'd3,         32'h80,   32'h300};
    vecs[3]  = '{MRET,   32'h70,  0, 0, 0, 32'h0,  32'h80,   32'h0,   32'h200, 32'h44,   1, 1, 32'h0,   32'h0,         32'h88,   32'h44};
    vecs[4]  = '{NOP,    32'h60,  0, 1, 1, 32'h80, 32'h8,    32'h80,  32'h400, 32'h0,    1, 0, 32'h80,  32'h80000007,  32'h80,   32'h400};
    vecs[5]  = '{ECALL,  32'h64,  0, 0, 1, 32'h90, 32'h8,    32'h880, 32'h400, 32'h0,    0, 0, 32'h0,   32'h0,         32'h0,    32'h0};
    vecs[6]  = '{NOP,    32'h68,  1, 0, 0, 32'h0,  32'h0,    32'h800, 32'h400, 32'h0,    0, 0, 32'h0,   32'h0,         32'h0,    32'h0};
    vecs[7]  = '{NOP,    32'h6c,  1, 1, 0, 32'h0,  32'h8,    32'h0,   32'h400, 32'h0,    0, 0, 32'h0,   32'h0,         32'h0,    32'h0};
    vecs[8]  = '{ECALL,  32'h74,  1, 0, 0, 32'h0,  32'h8,    32'h800, 32'h500, 32'h0,    1, 0, 32'h74,  32'd11,        32'h80,   32'h500};
    vecs[9]  = '{NOP,    32'h78,  1, 1, 0, 32'h0,  32'h1808, 32'h880, 32'h601, 32'h0,    1, 0, 32'h78,  32'h8000000B,  32'h1880, 32'h600};
    vecs[10] = '{MRET,   32'h7c,  0, 0, 0, 32'h0,  32'h1800, 32'h0,   32'h0,   32'h1234, 1, 1, 32'h0,   32'h0,         32'h1880, 32'h1234};
    vecs[11] = '{NOP,    32'h80,  0, 1, 0, 32'h0,  32'h8,    32'h880, 32'h700, 32'h0,    1, 0, 32'h80,  32'h80000007,  32'h80,   32'h700};
    vecs[12] = '{EBREAK, 32'h84,  1, 0, 1, 32'hA0, 32'h8,    32'h800, 32'h200, 32'h0,    1, 0, 32'hA0,  32'h8000000B,  32'h80,   32'h200};

    rst = 1'b1; stall = 1'b0; clear_events();
    id_addr = '0; jump_addr = '0; mtvec = '0; mepc = '0; mstatus = '0; mie = '0;
    @(posedge clk); #1;
    chk("rst_csr_we", csr_we, 1'b0);
    chk("rst_waddr", csr_waddr, 12'h0);
    chk("rst_wdata", csr_wdata, 32'h0);
    chk("rst_int_enable", int_enable, 1'b0);
    chk("rst_isr_addr", isr_addr, 32'h0);
    chk("rst_busy", int_busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    for (int i = 0; i < 13; i++) apply_vec(vecs[i]);

    // ext+timer together: ext first, no nesting while MIE=0, mret, then timer back-to-back.
    id_inst = NOP; id_addr = 32'h300; irq_ext = 1'b1; irq_timer = 1'b1;
    mstatus = 32'h8; mie = 32'h880; mtvec = 32'h800; mepc = 32'h0;
    #1;
    chk("busy_ext_first", int_busy, 1'b1);
    push_trap(32'h300, 32'h8000000B, 32'h80, 32'h800);
    repeat (4) step();
    mstatus = 32'h80;
    step();
    #1;
    chk("busy_no_nested", int_busy, 1'b0);
    irq_ext = 1'b0; id_inst = MRET; mepc = 32'h300;
    #1;
    chk("busy_mret", int_busy, 1'b1);
    push_ret(32'h88, 32'h300);
    step();
    id_inst = NOP; id_addr = 32'h304;
    step();
    mstatus = 32'h88;
    step();
    #1;
    chk("busy_timer_b2b", int_busy, 1'b1);
    push_trap(32'h304, 32'h80000007, 32'h80, 32'h800);
    step();
    irq_timer = 1'b0;
    repeat (5) step();

    // Reset in the middle of a trap: no further writes and no pulse.
    id_addr = 32'h500; irq_ext = 1'b1; mstatus = 32'h8; mie = 32'h800; mtvec = 32'h900;
    #1;
    chk("busy_pre_reset", int_busy, 1'b1);
    push(1'b0, 12'h341, 32'h500, 1);
    step();
    irq_ext = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("rst_mid_we", csr_we, 1'b0);
    chk("rst_mid_waddr", csr_waddr, 12'h0);
    chk("rst_mid_wdata", csr_wdata, 32'h0);
    chk("rst_mid_busy", int_busy, 1'b0);
    step();
    rst = 1'b0;
    repeat (5) step();

    // Stall holds off a pending IRQ; stall during the sequence is ignored.
    stall = 1'b1; irq_ext = 1'b1; id_addr = 32'h200; mtvec = 32'h240;
    mstatus = 32'h8; mie = 32'h800;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy_stalled", int_busy, 1'b0);
      step();
    end
    stall = 1'b0;
    #1;
    chk("busy_unstalled", int_busy, 1'b1);
    push_trap(32'h200, 32'h8000000B, 32'h80, 32'h240);
    step();
    irq_ext = 1'b0; stall = 1'b1;
    repeat (5) step();
    stall = 1'b0;
    step();

    chk("queue_drained", q.size(), 32'h0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
